dma_channel_arbiter: RTL
========================

DMA_CHANNEL_ARBITER -- requirements
Module: dma_channel_arbiter

Interface
REQ-001 Parameter CHANNELS, default 4 (from dmaRegConfigPkg), sets the number of DMA request channels.
REQ-002 Parameter HLDA_TIMEOUT, default 255, sets the maximum number of cycles HRQ waits for HLDA.
REQ-003 Port CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 Port RESET  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 Port DREQ  input  CHANNELS  per-channel request, active-high, level-sensitive.
REQ-006 Port maskIn  input  CHANNELS  per-channel mask; 1 excludes the channel from arbitration.
REQ-007 Port cmdDisable  input  1  controller disable; 1 blocks new arbitration.
REQ-008 Port HLDA  input  1  hold acknowledge from the CPU.
REQ-009 Port EOP_N  input  1  end of process, active-low; terminates the active service.
REQ-010 Port HRQ  output  1  hold request to the CPU.
REQ-011 Port DACK  output  CHANNELS  one-hot acknowledge, active-high.
REQ-012 Port activeChannel  output  $clog2(CHANNELS)  index of the granted channel; valid while any DACK bit is set.
REQ-013 Port timeoutErr  output  1  one-cycle pulse when the HLDA wait expires.

Function
REQ-014 The arbiter SHALL be a four-state FSM: IDLE, REQUEST, GRANT, RELEASE.
REQ-015 Pending vector = registered DREQ & ~maskIn; DREQ is registered once before use.
REQ-016 IDLE -> REQUEST when the pending vector is nonzero and cmdDisable=0; HRQ=1 from the first REQUEST cycle.
REQ-017 REQUEST: an 8-bit-wide counter (width $clog2(HLDA_TIMEOUT+1)) counts cycles; the counter clears on entry to REQUEST.
REQ-018 REQUEST with HLDA=1 and pending nonzero -> GRANT; the winner is latched on the HLDA edge, and DACK[winner]=1 on the first GRANT cycle.
REQ-019 REQUEST with HLDA=1 and pending zero (request withdrawn) -> RELEASE; no DACK is asserted.
REQ-020 REQUEST with the counter = HLDA_TIMEOUT and HLDA=0 -> IDLE; HRQ drops and timeoutErr pulses for one cycle.
REQ-021 GRANT holds DACK and activeChannel stable; maskIn, cmdDisable and other DREQ bits do not affect an active grant.
REQ-022 GRANT -> RELEASE on EOP_N=0 or on registered DREQ[activeChannel]=0; DACK=0 and HRQ=0 from the first RELEASE cycle.
REQ-023 GRANT with HLDA=0 (preemption) -> IDLE; DACK=0 and HRQ=0 in the next cycle.
REQ-024 RELEASE -> IDLE once HLDA=0; HRQ stays 0 throughout RELEASE.
REQ-025 Fixed priority: channel 0 is highest and CHANNELS-1 is lowest; ties resolve deterministically by index.
REQ-026 DACK SHALL never have more than one bit set; HRQ=0 implies DACK=0.
REQ-027 Simultaneous EOP_N=0 and HLDA=0 in GRANT: preemption (REQ-023) takes precedence.

Reset
REQ-028 RESET=0 forces the following immediately, in any state including mid-grant: state=IDLE, HRQ=0, DACK=0, activeChannel=0, timeoutErr=0, counter=0, registered DREQ=0, priority pointer=0.

Configuration
REQ-029 Macro ROTATING_PRIORITY_EN defined: the channel after the last serviced one becomes highest priority; the pointer updates on GRANT exit only, with wrap from CHANNELS-1 to 0.
REQ-030 Macro ROTATING_PRIORITY_EN undefined: fixed priority per REQ-025; no pointer register is synthesized.

Structure
REQ-031 The FSM state enum (arbState_t) and the CHANNELS constant SHALL reside in dmaRegConfigPkg, imported by wildcard.
REQ-032 The winner selection SHALL be one combinational sub-module, dma_priority_encoder (inputs: pending, pointer; outputs: one-hot grant, index, any).

Verification
REQ-033 The bench SHALL cover the following scenarios:
- DREQ=4'b0110, HLDA raised 3 cycles after HRQ -> DACK=4'b0010, activeChannel=1; EOP_N low -> DACK=0, HRQ=0 next cycle.
- With ROTATING_PRIORITY_EN: DREQ=4'b1111 held across 4 EOP-terminated services -> grant order 0,1,2,3, then wrap to 0.
- DREQ=4'b0001 with maskIn=4'b0001 -> HRQ stays 0; clearing the mask -> HRQ=1 two cycles later.
- HLDA held 0 with HLDA_TIMEOUT=8 -> HRQ drops after 8 REQUEST cycles; timeoutErr pulses once.
- In GRANT on channel 2, HLDA drops -> DACK=0, HRQ=0 next cycle, FSM IDLE.
- RESET=0 mid-GRANT, asserted asynchronously between edges -> HRQ=0 and DACK=0 immediately; after release, no grant until a new DREQ is seen.

Source files
------------

// File: rtl/dma_channel_arbiter_pkg.sv
// Shared configuration for the DMA channel arbiter: channel count and FSM state encoding.
package dmaRegConfigPkg;

    localparam int CHANNELS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } arbState_t;

endpackage

// File: rtl/dma_channel_arbiter_priority_encoder.sv
// Combinational winner selection: the first pending channel found when scanning upward from
// pointer, wrapping past CHANNELS-1. A zero pointer gives plain fixed priority (channel 0 highest).
module dma_priority_encoder #(
    parameter  int CHANNELS = 4,
    localparam int IW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic [CHANNELS-1:0] pending,
    input  logic [IW-1:0]       pointer,
    output logic [CHANNELS-1:0] grant,
    output logic [IW-1:0]       index,
    output logic                any
);

    logic [IW:0] slot;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        slot  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            slot = {1'b0, pointer} + (IW+1)'(i);
            if (slot >= (IW+1)'(CHANNELS)) begin
                slot = slot - (IW+1)'(CHANNELS);
            end
            if (!any && pending[slot[IW-1:0]]) begin
                any                = 1'b1;
                grant[slot[IW-1:0]] = 1'b1;
                index              = slot[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/dma_channel_arbiter.sv
// DMA channel arbiter: HRQ/HLDA handshake with the CPU and one-hot DACK to the winning channel.
// Define ROTATING_PRIORITY_EN to rotate priority to the channel after the last one serviced.
//
// state   | meaning
// IDLE    | no hold requested; waiting for an unmasked, enabled request
// REQUEST | HRQ driven, counting cycles until HLDA or timeout
// GRANT   | HLDA held, DACK asserted on the latched winner
// RELEASE | service finished or withdrawn, HRQ low, waiting for HLDA to drop
module dma_channel_arbiter #(
    parameter  int CHANNELS     = dmaRegConfigPkg::CHANNELS,
    parameter  int HLDA_TIMEOUT = 255,
    localparam int IW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CW           = $clog2(HLDA_TIMEOUT + 1)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [CHANNELS-1:0] DREQ,
    input  logic [CHANNELS-1:0] maskIn,
    input  logic                cmdDisable,
    input  logic                HLDA,
    input  logic                EOP_N,
    output logic                HRQ,
    output logic [CHANNELS-1:0] DACK,
    output logic [IW-1:0]       activeChannel,
    output logic                timeoutErr
);

    import dmaRegConfigPkg::*;

    arbState_t           state_q, state_d;
    logic [CHANNELS-1:0] dreq_q, pending, enc_grant, grant_q;
    logic [IW-1:0]       enc_index, active_q, pointer;
    logic                enc_any, timeout_hit, timeout_err_q;
    logic [CW-1:0]       cnt_q;

    assign pending     = dreq_q & ~maskIn;
    assign timeout_hit = (cnt_q == CW'(HLDA_TIMEOUT));

    dma_priority_encoder #(.CHANNELS(CHANNELS)) u_prio (
        .pending (pending),
        .pointer (pointer),
        .grant   (enc_grant),
        .index   (enc_index),
        .any     (enc_any)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Preemption (HLDA low) is tested before EOP so a simultaneous drop goes straight to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (|pending && !cmdDisable) state_d = REQUEST;
            end
            REQUEST: begin
                if (HLDA)             state_d = enc_any ? GRANT : RELEASE;
                else if (timeout_hit) state_d = IDLE;
            end
            GRANT: begin
                if (!HLDA)                             state_d = IDLE;
                else if (!EOP_N || !dreq_q[active_q])  state_d = RELEASE;
            end
            RELEASE: begin
                if (!HLDA) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        HRQ           = (state_q == REQUEST) || (state_q == GRANT);
        DACK          = (state_q == GRANT) ? grant_q : '0;
        activeChannel = active_q;
        timeoutErr    = timeout_err_q;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            dreq_q        <= '0;
            cnt_q         <= '0;
            grant_q       <= '0;
            active_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            dreq_q        <= DREQ;
            timeout_err_q <= (state_q == REQUEST) && !HLDA && timeout_hit;
            if (state_q != REQUEST) begin
                cnt_q <= '0;
            end else if (!timeout_hit) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == REQUEST && HLDA && enc_any) begin
                grant_q  <= enc_grant;
                active_q <= enc_index;
            end
        end
    end

`ifdef ROTATING_PRIORITY_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pointer <= '0;
        end else if (state_q == GRANT && state_d != GRANT) begin
            pointer <= (active_q == IW'(CHANNELS - 1)) ? '0 : active_q + 1'b1;
        end
    end
`else
    assign pointer = '0;
`endif

endmodule
